// File: rtl/fft2d_transpose_ctrl_if.sv
// fft2d_transpose_ctrl_if: stream-side bundle of the 2-D FFT corner-turn controller.
// Ports: s_valid/s_ready/s_data row-pass input, m_valid/m_ready/m_data/m_last column-order
//        output, frame_done/busy status. slave = controller view, master = environment view.
`ifndef FFT_DATA_WIDTH
`define FFT_DATA_WIDTH 16
`endif

interface fft2d_transpose_ctrl_if #(
  parameter int DATA_W = `FFT_DATA_WIDTH
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              frame_done;
  logic              busy;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last, frame_done, busy
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last, frame_done, busy
  );
endinterface

// File: rtl/fft2d_transpose_ctrl.sv
// fft2d_transpose_ctrl: corner-turn sequencer; writes row-major through RAM port 0 and
// reads column-major through port 1 into a 2-entry skid buffer (read latency 1 cycle).
// Ports: clk/rst, io (stream bundle), ram_*0 write port, ram_*1 read port.
// Backpressure: s_ready drops while no bank is free; reads stall to keep occ+inflight <= 2.
// Option macro FFT2D_TRANSPOSE_PINGPONG_EN: two banks, write and read run concurrently.
`ifndef FFT_DATA_WIDTH
`define FFT_DATA_WIDTH 16
`endif
`ifndef FFT2D_C_RAM_ADD_BITS
`define FFT2D_C_RAM_ADD_BITS 1
`endif
`ifndef RAM_ADD_WIDTH
`define RAM_ADD_WIDTH 6
`endif

module fft2d_transpose_ctrl #(
  parameter int DATA_W   = `FFT_DATA_WIDTH,
  parameter int ADDR_W   = `FFT2D_C_RAM_ADD_BITS + `RAM_ADD_WIDTH,
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  fft2d_transpose_ctrl_if.slave io,
  output logic [ADDR_W-1:0]     ram_addr0,
  output logic                  ram_cs0,
  output logic                  ram_we0,
  output logic                  ram_oe0,
  output logic [DATA_W-1:0]     ram_wdata0,
  output logic [ADDR_W-1:0]     ram_addr1,
  output logic                  ram_cs1,
  output logic                  ram_we1,
  output logic                  ram_oe1,
  input  logic [DATA_W-1:0]     ram_rdata1
);
  localparam int CNT_W = ROW_BITS + COL_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef FFT2D_TRANSPOSE_PINGPONG_EN
  localparam logic BANK_TOGGLE = 1'b1;
`else
  localparam logic BANK_TOGGLE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wcnt;      // {row, col}: col is the inner count
  logic [CNT_W-1:0]  rcnt;      // {col, row}: row is the inner count
  logic              wbank, rbank;
  logic              rdone;     // every read of the current bank has been issued
  logic [1:0]        full, full_nxt;
  logic              inflight, infl_last;
  logic [1:0]        occ;
  logic [DATA_W-1:0] buf0_dat, buf1_dat;
  logic              buf0_last, buf1_last;
  logic              s_rdy, wbeat, issue, pop, fdone;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    full_nxt  = full;
    s_rdy     = 1'b0;
`ifdef FFT2D_TRANSPOSE_PINGPONG_EN
    if (state != IDLE) s_rdy = !full[wbank];
`else
    s_rdy = (state == WRITE);
`endif
    wbeat = io.s_valid & s_rdy;
    pop   = (occ != 2'd0) & io.m_ready;
    fdone = pop & buf0_last;
    // Issue only if the data returning next cycle is guaranteed a skid slot.
    issue = full[rbank] & !rdone &
            (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
    if (wbeat && wcnt == CNT_MAX) full_nxt[wbank] = 1'b1;
    if (fdone)                    full_nxt[rbank] = 1'b0;
    case (state)
      IDLE:    state_nxt = WRITE;
      default: state_nxt = (|full_nxt) ? READ : WRITE;
    endcase
  end

  always_comb begin
    ram_addr0 = '0;
    ram_addr1 = '0;
    if (wbeat) ram_addr0[CNT_W:0] = {wbank, wcnt};
    if (issue) ram_addr1[CNT_W:0] = {rbank, rcnt[ROW_BITS-1:0], rcnt[CNT_W-1:ROW_BITS]};
  end

  assign ram_cs0    = wbeat;
  assign ram_we0    = wbeat;
  assign ram_oe0    = 1'b0;
  assign ram_wdata0 = wbeat ? io.s_data : '0;
  assign ram_cs1    = issue;
  assign ram_oe1    = issue;
  assign ram_we1    = 1'b0;

  assign io.s_ready    = s_rdy;
  assign io.m_valid    = (occ != 2'd0);
  assign io.m_data     = (occ != 2'd0) ? buf0_dat : '0;
  assign io.m_last     = (occ != 2'd0) & buf0_last;
  assign io.frame_done = fdone;
  assign io.busy       = (state != IDLE) &
                         ((wcnt != '0) | (|full) | (occ != 2'd0) | inflight);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt      <= '0;
      rcnt      <= '0;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      rdone     <= 1'b0;
      full      <= 2'b00;
      inflight  <= 1'b0;
      infl_last <= 1'b0;
      occ       <= 2'd0;
      buf0_dat  <= '0;
      buf1_dat  <= '0;
      buf0_last <= 1'b0;
      buf1_last <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wbeat) begin
        wcnt <= wcnt + CNT_W'(1);
        if (wcnt == CNT_MAX) wbank <= wbank ^ BANK_TOGGLE;
      end
      if (issue) begin
        rcnt <= rcnt + CNT_W'(1);
        if (rcnt == CNT_MAX) rdone <= 1'b1;
      end
      if (fdone) begin
        rdone <= 1'b0;
        rbank <= rbank ^ BANK_TOGGLE;
      end
      inflight  <= issue;
      infl_last <= issue & (rcnt == CNT_MAX);
      // Skid buffer: push = read data returning this cycle, pop = accepted beat.
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            buf0_dat  <= ram_rdata1;
            buf0_last <= infl_last;
          end else begin
            buf1_dat  <= ram_rdata1;
            buf1_last <= infl_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0_dat  <= buf1_dat;
          buf0_last <= buf1_last;
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0_dat  <= ram_rdata1;
            buf0_last <= infl_last;
          end else begin
            buf0_dat  <= buf1_dat;
            buf0_last <= buf1_last;
            buf1_dat  <= ram_rdata1;
            buf1_last <= infl_last;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fft2d_transpose_ctrl.sv
`timescale 1ns/1ps
module tb_fft2d_transpose_ctrl;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int RB = 2;
  localparam int CB = 2;
  localparam int R  = 1 << RB;
  localparam int C  = 1 << CB;
  localparam int N  = R * C;
`ifdef FFT2D_TRANSPOSE_PINGPONG_EN
  localparam int PP = 1;
`else
  localparam int PP = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft2d_transpose_ctrl_if #(.DATA_W(DW)) io ();
  logic [AW-1:0] ram_addr0, ram_addr1;
  logic          ram_cs0, ram_we0, ram_oe0, ram_cs1, ram_we1, ram_oe1;
  logic [DW-1:0] ram_wdata0, ram_rdata1;

  fft2d_transpose_ctrl #(.DATA_W(DW), .ADDR_W(AW), .ROW_BITS(RB), .COL_BITS(CB)) dut (
    .clk(clk), .rst(rst), .io(io),
    .ram_addr0(ram_addr0), .ram_cs0(ram_cs0), .ram_we0(ram_we0), .ram_oe0(ram_oe0),
    .ram_wdata0(ram_wdata0),
    .ram_addr1(ram_addr1), .ram_cs1(ram_cs1), .ram_we1(ram_we1), .ram_oe1(ram_oe1),
    .ram_rdata1(ram_rdata1)
  );

  // Dual-port RAM: synchronous write on port 0, registered read on port 1.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_cs0 && ram_we0) mem[ram_addr0] <= ram_wdata0;
    if (ram_cs1 && ram_oe1) ram_rdata1 <= mem[ram_addr1];
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic          o_sbeat, o_wbeat, o_sready, o_mvalid, o_mbeat, o_mlast, o_fdone, o_issue, o_busy;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata, o_mdata;

  // Reference model state: values are written as an RxC matrix row-major and must come
  // back column by column, in frame write order.
  logic [DW-1:0] src_q[$], exp_q[$], wr_frame[$], out_log[$], stall_log[$];
  int wr_k, rd_k, bank_w, pending, fdone_cnt, first_out_t, last_out_t;
  int fdone_t[$], fstart_t[$];

  task automatic model_reset();
    src_q.delete(); exp_q.delete(); wr_frame.delete();
    wr_k = 0; rd_k = 0; bank_w = 0; pending = 0;
  endtask

  task automatic clear_logs();
    out_log.delete(); stall_log.delete(); fdone_t.delete(); fstart_t.delete();
    fdone_cnt = 0; first_out_t = 0; last_out_t = 0;
  endtask

  task automatic load_seq(input int base, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(DW'(base + i));
  endtask

  // Observe mid-cycle (inputs settled, before the edge that acts on them).
  task automatic tick();
    @(negedge clk);
    o_sbeat  = io.s_valid & io.s_ready;
    o_sready = io.s_ready;
    o_wbeat  = ram_cs0 & ram_we0;
    o_waddr  = ram_addr0;
    o_wdata  = ram_wdata0;
    o_mvalid = io.m_valid;
    o_mbeat  = io.m_valid & io.m_ready;
    o_mdata  = io.m_data;
    o_mlast  = io.m_last;
    o_fdone  = io.frame_done;
    o_issue  = ram_cs1 & ram_oe1;
    o_busy   = io.busy;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // s_mode: 0 always valid, 1 toggle, 2 random. m_mode: 0 always ready, 1 random,
  // 2 stall 3 cycles with the 5th beat presented, 3 hold off until all input is sent.
  task automatic run_stream(input int s_mode, input int m_mode, input int stop_after, input int budget);
    int t = 0;
    int outs = 0;
    int held = 0;
    int iss = 0;
    int pops = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic exp_sready, exp_last;
    while ((src_q.size() != 0 || exp_q.size() != 0) && t < budget &&
           (stop_after == 0 || outs < stop_after)) begin
      io.s_valid = 1'b0;
      if (src_q.size() != 0) begin
        case (s_mode)
          0:       io.s_valid = 1'b1;
          1:       io.s_valid = (t % 2 == 0);
          default: io.s_valid = 1'($urandom_range(0, 1));
        endcase
      end
      io.s_data = (src_q.size() != 0) ? src_q[0] : DW'($urandom);
      case (m_mode)
        0: io.m_ready = 1'b1;
        1: io.m_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (outs == 4 && held < 3) begin
            io.m_ready = 1'b0;
            held++;
          end else io.m_ready = 1'b1;
        end
        default: begin
          if (src_q.size() == 0) held++;
          io.m_ready = (held > 4);
        end
      endcase
      tick();
      t++;

      exp_sready = (pending <= PP);
      checks++;
      if (o_sready !== exp_sready) begin
        errors++;
        $display("FAIL s_ready cyc=%0d got=%b exp=%b", cyc, o_sready, exp_sready);
      end
      checks++;
      if (o_wbeat !== o_sbeat) begin
        errors++;
        $display("FAIL wr_strobe cyc=%0d cs0&we0=%b exp=%b", cyc, o_wbeat, o_sbeat);
      end
      if (o_sbeat) begin
        checks++;
        if (o_waddr !== AW'(bank_w * N + wr_k) || o_wdata !== src_q[0]) begin
          errors++;
          $display("FAIL wr_beat cyc=%0d addr=%0d data=%0d exp addr=%0d data=%0d",
                   cyc, o_waddr, o_wdata, bank_w * N + wr_k, src_q[0]);
        end
        if (wr_k == 0) fstart_t.push_back(cyc);
        wr_frame.push_back(src_q.pop_front());
        wr_k++;
        if (wr_k == N) begin
          for (int j = 0; j < N; j++) exp_q.push_back(wr_frame[(j % R) * C + (j / R)]);
          wr_frame.delete();
          wr_k = 0;
          bank_w = bank_w ^ PP;
          pending++;
        end
      end

      if (prev_stall) begin
        checks++;
        if (!o_mvalid || o_mdata !== prev_data) begin
          errors++;
          $display("FAIL m_hold cyc=%0d valid=%b data=%0d exp data=%0d", cyc, o_mvalid, o_mdata, prev_data);
        end
      end
      prev_stall = o_mvalid & ~io.m_ready;
      prev_data  = o_mdata;
      if (o_mvalid && !io.m_ready) stall_log.push_back(o_mdata);

      checks++;
      if (o_mbeat) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL m_extra cyc=%0d data=%0d exp none", cyc, o_mdata);
        end else begin
          exp_last = (rd_k == N - 1);
          if (o_mdata !== exp_q[0] || o_mlast !== exp_last || o_fdone !== exp_last) begin
            errors++;
            $display("FAIL m_beat cyc=%0d data=%0d last=%b done=%b exp data=%0d last=%b done=%b",
                     cyc, o_mdata, o_mlast, o_fdone, exp_q[0], exp_last, exp_last);
          end
          out_log.push_back(o_mdata);
          void'(exp_q.pop_front());
          if (outs == 0) first_out_t = cyc;
          last_out_t = cyc;
          outs++;
          rd_k = (rd_k + 1) % N;
          if (exp_last) begin
            pending--;
            fdone_cnt++;
            fdone_t.push_back(cyc);
          end
        end
      end else if (o_fdone !== 1'b0) begin
        errors++;
        $display("FAIL frame_done_stray cyc=%0d got=%b exp=0", cyc, o_fdone);
      end

      if (o_issue) iss++;
      if (o_mbeat) pops++;
      checks++;
      if (iss - pops > 2) begin
        errors++;
        $display("FAIL outstanding cyc=%0d got=%0d exp<=2", cyc, iss - pops);
      end
    end
    io.s_valid = 1'b0;
    checks++;
    if ((src_q.size() != 0 || exp_q.size() != 0) && !(stop_after != 0 && outs >= stop_after)) begin
      errors++;
      $display("FAIL timeout cyc=%0d src_left=%0d out_left=%0d exp 0", cyc, src_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io.s_valid = 1'b1; io.s_data = 16'hbeef; io.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({io.s_ready, io.m_valid, io.m_last, io.frame_done, io.busy, ram_cs0, ram_we0,
         ram_oe0, ram_cs1, ram_we1, ram_oe1} !== 11'd0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0", {io.s_ready, io.m_valid, io.m_last, io.frame_done,
               io.busy, ram_cs0, ram_we0, ram_oe0, ram_cs1, ram_we1, ram_oe1});
    end
    checks++;
    if (ram_addr0 !== '0 || ram_addr1 !== '0 || ram_wdata0 !== '0 || io.m_data !== '0) begin
      errors++;
      $display("FAIL reset_bus addr0=%0d addr1=%0d wdata0=%0d m_data=%0d exp 0",
               ram_addr0, ram_addr1, ram_wdata0, io.m_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    io.s_valid = 1'b0;
    tick();
    checks++;
    if (o_sready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle s_ready=%b exp=0", o_sready);
    end
    tick();
    checks++;
    if (o_sready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_write s_ready=%b busy=%b exp 1 0", o_sready, o_busy);
    end
  endtask

  task automatic test_basic();
    clear_logs();
    load_seq(0, N);
    run_stream(0, 0, 0, 400);
    checks++;
    if (out_log.size() !== N || out_log[1] !== 16'd4 || out_log[4] !== 16'd1 || out_log[15] !== 16'd15) begin
      errors++;
      $display("FAIL basic_order n=%0d o1=%0d o4=%0d o15=%0d exp 16 4 1 15",
               out_log.size(), out_log[1], out_log[4], out_log[15]);
    end
    checks++;
    if (last_out_t - first_out_t !== N - 1 || fdone_cnt !== 1) begin
      errors++;
      $display("FAIL back_to_back span=%0d done=%0d exp %0d 1", last_out_t - first_out_t, fdone_cnt, N - 1);
    end
    tick();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy got=%b exp=0", o_busy);
    end
  endtask

  task automatic test_stall();
    clear_logs();
    load_seq(0, N);
    run_stream(0, 2, 0, 400);
    checks++;
    if (stall_log.size() !== 3 || stall_log[0] !== 16'd1 || stall_log[2] !== 16'd1) begin
      errors++;
      $display("FAIL stall_hold n=%0d first=%0d last=%0d exp 3 1 1",
               stall_log.size(), stall_log[0], stall_log[2]);
    end
    checks++;
    if (out_log.size() !== N || out_log[5] !== 16'd5) begin
      errors++;
      $display("FAIL stall_continue n=%0d o5=%0d exp 16 5", out_log.size(), out_log[5]);
    end
  endtask

  task automatic test_toggle();
    clear_logs();
    load_seq(0, N);
    run_stream(1, 0, 0, 400);
    for (int j = 0; j < N; j++) begin
      checks++;
      if (out_log[j] !== DW'((j % R) * C + j / R)) begin
        errors++;
        $display("FAIL toggle_out j=%0d got=%0d exp=%0d", j, out_log[j], (j % R) * C + j / R);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    load_seq(0, N);
    run_stream(0, 0, 6, 400);
    checks++;
    if (out_log.size() !== 6 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre n=%0d busy=%b exp 6 1", out_log.size(), o_busy);
    end
    io.s_valid = 1'b1; io.s_data = 16'h5a5a; io.m_ready = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if ({io.s_ready, io.m_valid, io.m_last, io.frame_done, io.busy, ram_cs0, ram_cs1} !== 7'd0 ||
        io.m_data !== '0 || ram_wdata0 !== '0) begin
      errors++;
      $display("FAIL mid_reset ctrl=%b m_data=%0d wdata0=%0d exp 0",
               {io.s_valid & io.s_ready, io.m_valid, io.m_last, io.frame_done, io.busy, ram_cs0, ram_cs1},
               io.m_data, ram_wdata0);
    end
    tick(); tick();
    rst = 1'b0;
    io.s_valid = 1'b0;
    model_reset();
    clear_logs();
    tick(); tick();
    load_seq(16, N);
    run_stream(0, 0, 0, 400);
    checks++;
    if (out_log.size() !== N || out_log[0] !== 16'd16 || out_log[1] !== 16'd20 || out_log[15] !== 16'd31) begin
      errors++;
      $display("FAIL mid_after n=%0d o0=%0d o1=%0d o15=%0d exp 16 16 20 31",
               out_log.size(), out_log[0], out_log[1], out_log[15]);
    end
  endtask

`ifdef FFT2D_TRANSPOSE_PINGPONG_EN
  task automatic test_pingpong();
    clear_logs();
    load_seq(0, N);
    load_seq(100, N);
    run_stream(0, 3, 0, 600);
    checks++;
    if (fdone_cnt !== 2 || out_log[0] !== 16'd0 || out_log[16] !== 16'd100 || out_log[31] !== 16'd115) begin
      errors++;
      $display("FAIL pingpong_order done=%0d o0=%0d o16=%0d o31=%0d exp 2 0 100 115",
               fdone_cnt, out_log[0], out_log[16], out_log[31]);
    end
    checks++;
    if (fstart_t.size() !== 2 || fstart_t[1] >= first_out_t) begin
      errors++;
      $display("FAIL pingpong_concurrent startB=%0d first_out=%0d exp startB<first_out",
               fstart_t[1], first_out_t);
    end
  endtask
`else
  task automatic test_exclusive();
    clear_logs();
    load_seq(200, 2 * N);
    run_stream(0, 0, 0, 600);
    checks++;
    if (fdone_cnt !== 2 || fstart_t.size() !== 2 || fstart_t[1] !== fdone_t[0] + 1) begin
      errors++;
      $display("FAIL exclusive_resume done=%0d startB=%0d exp done=2 startB=%0d",
               fdone_cnt, fstart_t[1], fdone_t[0] + 1);
    end
  endtask
`endif

  task automatic test_random();
    clear_logs();
    for (int i = 0; i < 3 * N; i++) src_q.push_back(DW'($urandom));
    run_stream(2, 1, 0, 2000);
    checks++;
    if (out_log.size() !== 3 * N || fdone_cnt !== 3) begin
      errors++;
      $display("FAIL random_count n=%0d done=%0d exp %0d 3", out_log.size(), fdone_cnt, 3 * N);
    end
  endtask

  initial begin
    io.s_valid = 1'b0; io.s_data = '0; io.m_ready = 1'b0;
    model_reset();
    clear_logs();
    test_reset();
    test_basic();
    test_stall();
    test_toggle();
    test_reset_mid();
`ifdef FFT2D_TRANSPOSE_PINGPONG_EN
    test_pingpong();
`else
    test_exclusive();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
